// File: rtl/ps2kbd_pkg.sv
// rtl/ps2kbd_pkg.sv - shared parser states, scan-code constants and display helpers
package ps2kbd_pkg;

  // Parser position within a set-2 make/break/extended sequence
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } parse_state_t;

  localparam logic [7:0] PS2_BRK     = 8'hF0;
  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_PAUSE   = 8'hE1;
  localparam logic [7:0] PS2_OVERRUN = 8'h00;
  localparam logic [7:0] PS2_ERROR   = 8'hFF;
  localparam logic [7:0] LSHIFT      = 8'h12;
  localparam logic [7:0] RSHIFT      = 8'h59;
  localparam logic [7:0] CAPS        = 8'h58;

  // All segments dark for the given drive polarity
  function automatic logic [7:0] seg_blank(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/ps2kbd_decoder_if.sv
// rtl/ps2kbd_decoder_if.sv - PS/2 receiver FIFO pop handshake
interface ps2kbd_decoder_if;

  logic [7:0] data;
  logic       ready;
  logic       nextdata_n;

  // FIFO side presents the head byte; decoder side pops it
  modport master (output data, output ready, input nextdata_n);
  modport slave  (input data, input ready, output nextdata_n);

endinterface

// File: rtl/bcd8seg.sv
// rtl/bcd8seg.sv - hex nibble to 7-segment plus dp encoding
module bcd8seg #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  logic [7:0] seg_al;

  // Active-low pattern {dp,g,f,e,d,c,b,a}; dp always dark
  always_comb begin
    seg_al = 8'hFF;
    case (bcd)
      4'h0: seg_al = 8'hC0;  4'h1: seg_al = 8'hF9;  4'h2: seg_al = 8'hA4;
      4'h3: seg_al = 8'hB0;  4'h4: seg_al = 8'h99;  4'h5: seg_al = 8'h92;
      4'h6: seg_al = 8'h82;  4'h7: seg_al = 8'hF8;  4'h8: seg_al = 8'h80;
      4'h9: seg_al = 8'h90;  4'hA: seg_al = 8'h88;  4'hB: seg_al = 8'h83;
      4'hC: seg_al = 8'hC6;  4'hD: seg_al = 8'hA1;  4'hE: seg_al = 8'h86;
      4'hF: seg_al = 8'h8E;
      default: seg_al = 8'hFF;
    endcase
  end

  assign seg = ACTIVE_LOW ? seg_al : ~seg_al;

endmodule

// File: rtl/ps2kbd_ascii_rom.sv
// rtl/ps2kbd_ascii_rom.sv - set-2 scan code to lower-case ASCII lookup
module ps2kbd_ascii_rom (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  // Unmapped codes read as 00 so the display shows a neutral value
  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;  8'h66: ascii = 8'h08;
      8'h0D: ascii = 8'h09;  8'h76: ascii = 8'h1B;  8'h4E: ascii = 8'h2D;
      8'h55: ascii = 8'h3D;  8'h54: ascii = 8'h5B;  8'h5B: ascii = 8'h5D;
      8'h5D: ascii = 8'h5C;  8'h4C: ascii = 8'h3B;  8'h52: ascii = 8'h27;
      8'h41: ascii = 8'h2C;  8'h49: ascii = 8'h2E;  8'h4A: ascii = 8'h2F;
      8'h0E: ascii = 8'h60;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2kbd_decoder.sv
// rtl/ps2kbd_decoder.sv - PS/2 set-2 key decoder with 7-segment output; PS2KBD_REPEAT_EN reports typematic repeats
module ps2kbd_decoder
  import ps2kbd_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        clrn,
  ps2kbd_decoder_if.slave             fifo,
  output logic                        key_valid,
  output logic [7:0]                  key_code,
  output logic                        key_ext,
  output logic [7:0]                  key_ascii,
  output logic                        key_pressed,
  output logic                        key_repeat,
  output logic                        shift,
  output logic                        caps,
  output logic [4*(NUM_DIGITS-4)-1:0] key_cnt,
  output logic [8*NUM_DIGITS-1:0]     hex_o
);

  localparam int CNT_W = 4 * (NUM_DIGITS - 4);

  if (NUM_DIGITS < 5) begin : g_param_check
    $error("ps2kbd_decoder: NUM_DIGITS must be at least 5");
  end

  logic         nextdata_n_r;
  logic         consume;
  parse_state_t state, state_next;
  logic         ev_make, ev_break, ev_ext;
  logic         is_held, is_repeat, is_new, rep_pulse;
  logic         lshift, rshift;
  logic [7:0]   ascii_lc, ascii_cased;
  logic         is_letter;

  // A byte is taken only on a high strobe cycle, so each byte is popped once
  assign consume         = fifo.ready && nextdata_n_r;
  assign fifo.nextdata_n = nextdata_n_r;

  // Pop strobe: low for the cycle after a sample, then forced high again
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) nextdata_n_r <= 1'b1;
    else       nextdata_n_r <= !consume;
  end

  // Parser state register, advanced once per consumed byte
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= NORMAL;
    else       state <= state_next;
  end

  // Prefix tracking: E0 marks extended, F0 marks break
  always_comb begin
    state_next = state;
    if (consume) begin
      case (state)
        NORMAL: begin
          if (fifo.data == PS2_EXT)      state_next = EXT;
          else if (fifo.data == PS2_BRK) state_next = BRK;
          else                           state_next = NORMAL;
        end
        EXT: begin
          if (fifo.data == PS2_BRK)      state_next = EXT_BRK;
          else if (fifo.data == PS2_EXT) state_next = EXT;
          else                           state_next = NORMAL;
        end
        default: state_next = NORMAL;
      endcase
    end
  end

  // Classify the consumed byte as a make or break event for the datapath
  always_comb begin
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (consume) begin
      case (state)
        NORMAL: ev_make = !(fifo.data inside {PS2_EXT, PS2_BRK, PS2_PAUSE,
                                              PS2_OVERRUN, PS2_ERROR});
        EXT: begin
          ev_make = (fifo.data != PS2_BRK) && (fifo.data != PS2_EXT);
          ev_ext  = 1'b1;
        end
        BRK: ev_break = 1'b1;
        default: begin
          ev_break = 1'b1;
          ev_ext   = 1'b1;
        end
      endcase
    end
  end

  assign is_held   = key_pressed && (fifo.data == key_code) && (ev_ext == key_ext);
  assign is_repeat = ev_make && is_held;
  assign is_new    = ev_make && !is_held;

`ifdef PS2KBD_REPEAT_EN
  assign rep_pulse = is_repeat;
`else
  assign rep_pulse = 1'b0;
`endif

  ps2kbd_ascii_rom u_ascii_rom (
    .code  (fifo.data),
    .ascii (ascii_lc)
  );

  // Case is resolved at make time so a release keeps the character shown
  assign is_letter   = (ascii_lc >= 8'h61) && (ascii_lc <= 8'h7A);
  assign ascii_cased = (is_letter && (shift ^ caps)) ? (ascii_lc - 8'h20) : ascii_lc;
  assign shift       = lshift | rshift;

  // Modifier flags: shifts follow make/break, Caps Lock toggles on fresh press
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
      caps   <= 1'b0;
    end else begin
      if (!ev_ext && fifo.data == LSHIFT) begin
        if (ev_make)       lshift <= 1'b1;
        else if (ev_break) lshift <= 1'b0;
      end
      if (!ev_ext && fifo.data == RSHIFT) begin
        if (ev_make)       rshift <= 1'b1;
        else if (ev_break) rshift <= 1'b0;
      end
      if (ev_make && !ev_ext && fifo.data == CAPS && !is_repeat) caps <= ~caps;
    end
  end

  // Held-key record, distinct-press counter and event pulses
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_ascii   <= 8'h00;
      key_pressed <= 1'b0;
      key_cnt     <= '0;
      key_valid   <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_valid  <= is_new | rep_pulse;
      key_repeat <= rep_pulse;
      if (is_new) begin
        key_code    <= fifo.data;
        key_ext     <= ev_ext;
        key_ascii   <= ascii_cased;
        key_pressed <= 1'b1;
        key_cnt     <= key_cnt + CNT_W'(1);
      end else if (ev_break && is_held) begin
        key_pressed <= 1'b0;
      end
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [3:0] nib;
    logic [7:0] seg;
    if (d < 2) begin : g_code
      assign nib = key_code[4*d +: 4];
    end else if (d < 4) begin : g_ascii
      assign nib = key_ascii[4*(d-2) +: 4];
    end else begin : g_cnt
      assign nib = key_cnt[4*(d-4) +: 4];
    end
    bcd8seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
      .bcd (nib),
      .seg (seg)
    );
    if (d < 4) begin : g_blank
      assign hex_o[8*d +: 8] = key_pressed ? seg : seg_blank(SEG_ACTIVE_LOW);
    end else begin : g_show
      assign hex_o[8*d +: 8] = seg;
    end
  end

endmodule

// File: tb/tb_ps2kbd_decoder.sv
// tb/tb_ps2kbd_decoder.sv - randomized and directed checks of ps2kbd_decoder against a key-event model
module tb_ps2kbd_decoder;

`ifdef PS2KBD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk;
  logic        clrn;
  logic        key_valid, key_ext, key_pressed, key_repeat, shift, caps;
  logic [7:0]  key_code, key_ascii, key_cnt;
  logic [47:0] hex_o;

  ps2kbd_decoder_if fifo_if ();

  ps2kbd_decoder #(.NUM_DIGITS(6), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .fifo        (fifo_if),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_ascii   (key_ascii),
    .key_pressed (key_pressed),
    .key_repeat  (key_repeat),
    .shift       (shift),
    .caps        (caps),
    .key_cnt     (key_cnt),
    .hex_o       (hex_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int rep_pulses = 0;
  int ndn_lows = 0;
  bit mon_en = 1'b0;
  bit stall_en = 1'b0;
  bit prev_ready = 1'b0;
  bit prev_ndn = 1'b1;
  logic [7:0] q[$];

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] misc_codes [16] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h4E, 8'h55, 8'h54,
                                  8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E};
  logic [7:0] misc_chars [16] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B, 8'h2D, 8'h3D, 8'h5B,
                                  8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h60};
  logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0,
                            8'h00, 8'hFF, 8'hE1, 8'h75, 8'h6B, 8'h45, 8'h29, 8'h5A, 8'h4A, 8'h66};

  // Key-event model: pending prefixes plus the held-key record
  bit         m_ext_pend, m_brk_pend, m_kext, m_pressed, m_lsh, m_rsh, m_caps, m_valid, m_rep;
  logic [7:0] m_code, m_ascii, m_cnt;

  function automatic void model_reset();
    m_ext_pend = 0; m_brk_pend = 0; m_kext = 0; m_pressed = 0;
    m_lsh = 0; m_rsh = 0; m_caps = 0; m_valid = 0; m_rep = 0;
    m_code = 8'h00; m_ascii = 8'h00; m_cnt = 8'h00;
  endfunction

  function automatic logic [7:0] ascii_of(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (letter_codes[i] == c) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (digit_codes[i] == c) return 8'h30 + 8'(i);
    for (int i = 0; i < 16; i++) if (misc_codes[i] == c) return misc_chars[i];
    return 8'h00;
  endfunction

  function automatic void do_make(input logic [7:0] c, input bit e);
    logic [7:0] a;
    bit same;
    same = m_pressed && (c == m_code) && (e == m_kext);
    a = ascii_of(c);
    if (a >= 8'h61 && a <= 8'h7A && ((m_lsh || m_rsh) != m_caps)) a = a - 8'h20;
    if (!e && c == 8'h12) m_lsh = 1;
    if (!e && c == 8'h59) m_rsh = 1;
    if (!e && c == 8'h58 && !same) m_caps = !m_caps;
    if (same) begin
      if (REP_EN) begin m_valid = 1; m_rep = 1; end
    end else begin
      m_code = c; m_kext = e; m_ascii = a; m_pressed = 1;
      m_cnt = m_cnt + 8'h01; m_valid = 1;
    end
  endfunction

  function automatic void do_break(input logic [7:0] c, input bit e);
    if (!e && c == 8'h12) m_lsh = 0;
    if (!e && c == 8'h59) m_rsh = 0;
    if (m_pressed && c == m_code && e == m_kext) m_pressed = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_brk_pend) begin
      do_break(b, m_ext_pend);
      m_brk_pend = 0; m_ext_pend = 0;
    end else if (b == 8'hF0) m_brk_pend = 1;
    else if (b == 8'hE0) m_ext_pend = 1;
    else if (!m_ext_pend && (b == 8'h00 || b == 8'hFF || b == 8'hE1)) begin
    end else begin
      do_make(b, m_ext_pend);
      m_ext_pend = 0;
    end
  endfunction

  function automatic logic [47:0] exp_hex();
    logic [47:0] h;
    logic [3:0]  nib;
    h = '0;
    for (int d = 0; d < 6; d++) begin
      case (d)
        0: nib = m_code[3:0];
        1: nib = m_code[7:4];
        2: nib = m_ascii[3:0];
        3: nib = m_ascii[7:4];
        4: nib = m_cnt[3:0];
        default: nib = m_cnt[7:4];
      endcase
      h[8*d +: 8] = (d < 4 && !m_pressed) ? 8'hFF : seg_tab[nib];
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // FIFO emulation and per-cycle comparison, sampled on the falling edge
  initial begin : monitor
    logic exp_ndn;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_ndn = !(prev_ready && prev_ndn);
        chk("nextdata_n", 64'(fifo_if.nextdata_n), 64'(exp_ndn));
        m_valid = 0; m_rep = 0;
        if (fifo_if.nextdata_n == 1'b0) begin
          ndn_lows++;
          chk("pop_from_nonempty", 64'(q.size() != 0), 64'(1));
          if (q.size() != 0) begin
            b = q.pop_front();
            model_byte(b);
          end
        end
        if (key_valid) pulses++;
        if (key_repeat) rep_pulses++;
        chk("key_valid", 64'(key_valid), 64'(m_valid));
        chk("key_repeat", 64'(key_repeat), 64'(m_rep));
        chk("key_code", 64'(key_code), 64'(m_code));
        chk("key_ext", 64'(key_ext), 64'(m_kext));
        chk("key_ascii", 64'(key_ascii), 64'(m_ascii));
        chk("key_pressed", 64'(key_pressed), 64'(m_pressed));
        chk("shift", 64'(shift), 64'(m_lsh || m_rsh));
        chk("caps", 64'(caps), 64'(m_caps));
        chk("key_cnt", 64'(key_cnt), 64'(m_cnt));
        chk("hex_o", 64'(hex_o), 64'(exp_hex()));
        fifo_if.ready = (q.size() != 0) && !(stall_en && $urandom_range(0, 3) == 0);
        fifo_if.data  = fifo_if.ready ? q[0] : 8'($urandom);
        prev_ready = fifo_if.ready;
        prev_ndn   = fifo_if.nextdata_n;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    q.push_back(b);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(q.size() == 0 && fifo_if.nextdata_n == 1'b1) && n < budget);
    chk({"drain_", tag}, 64'(n < budget), 64'(1));
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    clrn = 1'b1;
    model_reset();
    prev_ready = fifo_if.ready;
    prev_ndn = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin : main
    int p0, r0, l0, found;
    logic [7:0] c;
    clrn = 1'b0;
    fifo_if.ready = 1'b0;
    fifo_if.data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_nextdata_n", 64'(fifo_if.nextdata_n), 64'(1));
    chk("reset_key_cnt", 64'(key_cnt), 64'(0));
    chk("reset_key_valid", 64'(key_valid), 64'(0));
    chk("reset_hex", 64'(hex_o), 64'(48'hC0C0_FFFF_FFFF));
    release_reset();

    // Single key: make, break
    p0 = pulses; l0 = ndn_lows;
    push(8'h1C); push(8'hF0); push(8'h1C);
    wait_idle(200, "t_a");
    chk("a_pulses", 64'(pulses - p0), 64'(1));
    chk("a_code", 64'(key_code), 64'(8'h1C));
    chk("a_ascii", 64'(key_ascii), 64'(8'h61));
    chk("a_cnt", 64'(key_cnt), 64'(1));
    chk("a_released", 64'(key_pressed), 64'(0));
    chk("a_pops", 64'(ndn_lows - l0), 64'(3));

    // Shifted letter
    push(8'h12); push(8'h1C);
    wait_idle(200, "t_shift_a");
    chk("shA_ascii", 64'(key_ascii), 64'(8'h41));
    chk("shA_shift", 64'(shift), 64'(1));
    push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
    wait_idle(200, "t_shift_b");
    chk("shA_shift_off", 64'(shift), 64'(0));
    chk("shA_cnt", 64'(key_cnt), 64'(3));
    chk("shA_ascii_kept", 64'(key_ascii), 64'(8'h41));

    // Extended key then the plain key with the same code
    push(8'hE0); push(8'h75);
    wait_idle(200, "t_ext_a");
    chk("ext_flag", 64'(key_ext), 64'(1));
    chk("ext_code", 64'(key_code), 64'(8'h75));
    chk("ext_cnt", 64'(key_cnt), 64'(4));
    push(8'hE0); push(8'hF0); push(8'h75); push(8'h75);
    wait_idle(200, "t_ext_b");
    chk("plain_flag", 64'(key_ext), 64'(0));
    chk("plain_cnt", 64'(key_cnt), 64'(5));
    push(8'hF0); push(8'h75);
    wait_idle(200, "t_ext_c");
    chk("plain_released", 64'(key_pressed), 64'(0));

    // Typematic repeat
    p0 = pulses; r0 = rep_pulses;
    repeat (5) push(8'h1C);
    push(8'hF0); push(8'h1C);
    wait_idle(300, "t_rep");
    chk("rep_cnt", 64'(key_cnt), 64'(6));
    chk("rep_valid_pulses", 64'(pulses - p0), 64'(REP_EN ? 5 : 1));
    chk("rep_repeat_pulses", 64'(rep_pulses - r0), 64'(REP_EN ? 4 : 0));

    // Overrun/pause bytes mid-stream are consumed without effect
    p0 = pulses; l0 = ndn_lows;
    push(8'h1C); push(8'h00); push(8'hE1); push(8'hFF);
    wait_idle(200, "t_noise");
    chk("noise_pops", 64'(ndn_lows - l0), 64'(4));
    chk("noise_pulses", 64'(pulses - p0), 64'(1));
    chk("noise_cnt", 64'(key_cnt), 64'(7));
    chk("noise_held", 64'(key_pressed), 64'(1));

    // Reset while a pop strobe is low, parser left in the extended state
    push(8'hE0); push(8'h32); push(8'h21);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk); #1;
      if (fifo_if.nextdata_n == 1'b0) found = 1;
    end
    chk("midpop_seen", 64'(found), 64'(1));
    #2;
    mon_en = 1'b0;
    clrn = 1'b0;
    fifo_if.ready = 1'b1;
    #1;
    chk("midpop_ndn", 64'(fifo_if.nextdata_n), 64'(1));
    chk("midpop_cnt", 64'(key_cnt), 64'(0));
    chk("midpop_hex_blank", 64'(hex_o[31:0]), 64'(32'hFFFF_FFFF));
    repeat (2) @(negedge clk);
    chk("midpop_ndn_held", 64'(fifo_if.nextdata_n), 64'(1));
    q.delete();
    fifo_if.ready = 1'b0;
    release_reset();
    push(8'h1C);
    wait_idle(200, "t_after_rst");
    chk("rst_parser_normal", 64'(key_ext), 64'(0));
    chk("rst_code", 64'(key_code), 64'(8'h1C));
    chk("rst_cnt", 64'(key_cnt), 64'(1));

    // Counter wrap
    for (int i = 0; i < 254; i++) push((i % 2 == 0) ? 8'h32 : 8'h1C);
    wait_idle(2000, "t_wrap_a");
    chk("wrap_ff", 64'(key_cnt), 64'(8'hFF));
    push(8'h32);
    wait_idle(200, "t_wrap_b");
    chk("wrap_00", 64'(key_cnt), 64'(8'h00));
    chk("wrap_hex_cnt", 64'(hex_o[47:32]), 64'(16'hC0C0));
    push(8'hF0); push(8'h32);
    wait_idle(200, "t_wrap_c");

    // Randomized key streams with FIFO stalls
    stall_en = 1'b1;
    for (int t = 0; t < 1200; t++) begin
      c = pool[$urandom_range(0, 19)];
      case ($urandom_range(0, 7))
        0, 1, 2: push(c);
        3, 4: begin push(8'hF0); push(c); end
        5: begin push(8'hE0); push(c); end
        6: begin push(8'hE0); push(8'hF0); push(c); end
        default: begin push(c); push(c); push(c); end
      endcase
    end
    wait_idle(40000, "t_random");
    stall_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
